// File: rtl/ov_seq_if.sv
// OV sensor sequencer bus: host controls, sensor sync pins and
// sensor power/clock/control outputs.
interface ov_seq_if #(
  parameter int CNT_W = 16
) ();
  logic             cam_en;
  logic             pwdn_req;
  logic             ov_vsync;
  logic             ov_href;
  logic             ov_vcc;
  logic             ov_gnd;
  logic             ov_xclk;
  logic             ov_rstn;
  logic             ov_pwdn;
  logic             ready;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] line_cnt;

  modport master (
    output cam_en, pwdn_req, ov_vsync, ov_href,
    input  ov_vcc, ov_gnd, ov_xclk, ov_rstn, ov_pwdn,
    input  ready, frame_cnt, line_cnt
  );

  modport slave (
    input  cam_en, pwdn_req, ov_vsync, ov_href,
    output ov_vcc, ov_gnd, ov_xclk, ov_rstn, ov_pwdn,
    output ready, frame_cnt, line_cnt
  );
endinterface

// File: rtl/ov_seq.sv
// OV camera power-up sequencer: rail, xclk and reset timing,
// standby control, and frame/line counting from sync pins.
module ov_seq #(
  parameter int CLK_DIV = 4,
  parameter int T_PWR   = 1000,
  parameter int T_RST   = 1000,
  parameter int T_RDY   = 5000,
  parameter int CNT_W   = 16
) (
  input logic   clk_sys,
  input logic   rst_n,
  ov_seq_if.slave bus
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TM1  = (T_PWR > T_RST) ? T_PWR : T_RST;
  localparam int TMAX = (TM1 > T_RDY) ? TM1 : T_RDY;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_OFF, S_PWR_UP, S_CLK_ON, S_RST_REL, S_RUN, S_STBY
  } state_t;

  // {vcc, xclk_en, rstn, pwdn, ready}
  typedef logic [4:0] out_t;

  localparam out_t O_OFF  = 5'b00010;
  localparam out_t O_PWR  = 5'b10010;
  localparam out_t O_CLK  = 5'b11000;
  localparam out_t O_RREL = 5'b11100;
  localparam out_t O_RUN  = 5'b11101;
  localparam out_t O_STBY = 5'b11110;

  state_t           r_state;
  out_t             r_out;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_frame;
  logic [CNT_W-1:0] r_line;
  logic [DW-1:0]    r_div;
  logic             r_xclk;
  logic [2:0]       r_vs;
  logic [2:0]       r_hs;

  logic w_vs_rise;
  logic w_hs_rise;

  assign w_vs_rise = r_vs[1] & ~r_vs[2];
  assign w_hs_rise = r_hs[1] & ~r_hs[2];

  // Two-flop synchronisers plus one history flop for edge detect.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_vs <= '0;
      r_hs <= '0;
    end else begin
      r_vs <= {r_vs[1:0], bus.ov_vsync};
      r_hs <= {r_hs[1:0], bus.ov_href};
    end
  end

  // Sequencer FSM with registered pin outputs and sync counters.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_out   <= O_OFF;
      r_wait  <= '0;
      r_frame <= '0;
      r_line  <= '0;
    end else if (!bus.cam_en) begin
      r_state <= S_OFF;
      r_out   <= O_OFF;
      r_wait  <= '0;
      r_frame <= '0;
      r_line  <= '0;
    end else begin
      unique case (r_state)
        S_OFF: begin
          r_state <= S_PWR_UP;
          r_out   <= O_PWR;
          r_wait  <= TW'(T_PWR - 1);
        end
        S_PWR_UP: begin
          if (r_wait == '0) begin
            r_state <= S_CLK_ON;
            r_out   <= O_CLK;
            r_wait  <= TW'(T_RST - 1);
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_CLK_ON: begin
          if (r_wait == '0) begin
            r_state <= S_RST_REL;
            r_out   <= O_RREL;
            r_wait  <= TW'(T_RDY - 1);
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RST_REL: begin
          if (r_wait == '0) begin
            r_state <= S_RUN;
            r_out   <= O_RUN;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RUN: begin
          if (bus.pwdn_req) begin
            r_state <= S_STBY;
            r_out   <= O_STBY;
          end
          if (w_vs_rise) begin
            r_frame <= r_frame + 1'b1;
            r_line  <= '0;
          end else if (w_hs_rise && r_line != '1) begin
            r_line <= r_line + 1'b1;
          end
        end
        S_STBY: begin
          if (!bus.pwdn_req) begin
            r_state <= S_RUN;
            r_out   <= O_RUN;
          end
        end
        default: begin
          r_state <= S_OFF;
          r_out   <= O_OFF;
        end
      endcase
    end
  end

  // xclk divider; cleared whenever the clock is (or is about to be) off.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_xclk <= 1'b0;
    end else if (!r_out[3] || !bus.cam_en) begin
      r_div  <= '0;
      r_xclk <= 1'b0;
    end else if (r_div == DW'(HALF - 1)) begin
      r_div  <= '0;
      r_xclk <= ~r_xclk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign bus.ov_vcc    = r_out[4];
  assign bus.ov_gnd    = 1'b0;
  assign bus.ov_xclk   = r_xclk;
  assign bus.ov_rstn   = r_out[2];
  assign bus.ov_pwdn   = r_out[1];
  assign bus.ready     = r_out[0];
  assign bus.frame_cnt = r_frame;
  assign bus.line_cnt  = r_line;

endmodule

// File: tb/tb_ov_seq.sv
// Directed bench for ov_seq: power-up timing table plus
// abort, standby, counting, wrap/saturate and reset sequences.
module tb_ov_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ov_seq_if #(.CNT_W(4)) bus ();

  ov_seq #(
    .CLK_DIV(4),
    .T_PWR  (8),
    .T_RST  (4),
    .T_RDY  (6),
    .CNT_W  (4)
  ) dut (
    .clk_sys(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {vcc, gnd, xclk, rstn, pwdn, ready}
  typedef struct {
    int         cyc;
    logic [5:0] pins;
  } vec_t;

  vec_t tab[11];

  localparam logic [5:0] P_OFF = 6'b000010;

  function automatic logic [5:0] pins();
    return {bus.ov_vcc, bus.ov_gnd, bus.ov_xclk,
            bus.ov_rstn, bus.ov_pwdn, bus.ready};
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pins(string nm, logic [5:0] exp);
    checks++;
    if (pins() !== exp) begin
      failures++;
      $display("FAIL %s: pins got %b expected %b", nm, pins(), exp);
    end
  endtask

  // Raise cam_en and walk the timing table; cycle k follows edge k.
  task automatic run_pwrup(string tag);
    int k;
    k = 0;
    bus.cam_en = 1'b1;
    foreach (tab[i]) begin
      while (k < tab[i].cyc) begin
        @(posedge clk);
        k++;
      end
      #1;
      chk_pins($sformatf("%s_c%0d", tag, tab[i].cyc), tab[i].pins);
    end
  endtask

  task automatic pulse(logic v, logic h);
    @(negedge clk);
    bus.ov_vsync = v;
    bus.ov_href  = h;
    repeat (2) @(negedge clk);
    bus.ov_vsync = 1'b0;
    bus.ov_href  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int  tog;
    logic p;
    checks   = 0;
    failures = 0;
    tab[0]  = '{0,  6'b000010};
    tab[1]  = '{1,  6'b100010};
    tab[2]  = '{8,  6'b100010};
    tab[3]  = '{9,  6'b100000};
    tab[4]  = '{10, 6'b100000};
    tab[5]  = '{11, 6'b101000};
    tab[6]  = '{12, 6'b101000};
    tab[7]  = '{13, 6'b100100};
    tab[8]  = '{15, 6'b101100};
    tab[9]  = '{18, 6'b100100};
    tab[10] = '{19, 6'b101101};

    rst_n        = 1'b0;
    bus.cam_en   = 1'b0;
    bus.pwdn_req = 1'b0;
    bus.ov_vsync = 1'b0;
    bus.ov_href  = 1'b0;
    repeat (3) @(negedge clk);
    chk_pins("reset_pins", P_OFF);
    chk("reset_frame", int'(bus.frame_cnt), 0);
    chk("reset_line", int'(bus.line_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_pins("idle_off", P_OFF);

    @(negedge clk);
    run_pwrup("pwrup");

    for (int f = 0; f < 3; f++) begin
      pulse(1'b1, 1'b0);
      for (int l = 0; l < 5; l++) pulse(1'b0, 1'b1);
    end
    chk("count_frame", int'(bus.frame_cnt), 3);
    chk("count_line", int'(bus.line_cnt), 5);
    pulse(1'b1, 1'b1);
    chk("both_frame", int'(bus.frame_cnt), 4);
    chk("both_line", int'(bus.line_cnt), 0);
    pulse(1'b0, 1'b1);
    chk("line_after_both", int'(bus.line_cnt), 1);

    @(negedge clk);
    bus.pwdn_req = 1'b1;
    @(posedge clk);
    #1;
    chk("stby_pwdn", int'(bus.ov_pwdn), 1);
    chk("stby_ready", int'(bus.ready), 0);
    chk("stby_rstn", int'(bus.ov_rstn), 1);
    tog = 0;
    p = bus.ov_xclk;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.ov_xclk !== p) tog++;
      p = bus.ov_xclk;
    end
    chk("stby_xclk_toggles", tog, 2);
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    chk("stby_frame_hold", int'(bus.frame_cnt), 4);
    chk("stby_line_hold", int'(bus.line_cnt), 1);
    @(negedge clk);
    bus.pwdn_req = 1'b0;
    @(posedge clk);
    #1;
    chk("wake_ready", int'(bus.ready), 1);
    chk("wake_pwdn", int'(bus.ov_pwdn), 0);
    chk("wake_frame", int'(bus.frame_cnt), 4);
    chk("wake_line", int'(bus.line_cnt), 1);

    for (int f = 0; f < 13; f++) pulse(1'b1, 1'b0);
    chk("wrap_frame", int'(bus.frame_cnt), 1);
    for (int l = 0; l < 20; l++) pulse(1'b0, 1'b1);
    chk("sat_line", int'(bus.line_cnt), 15);

    @(negedge clk);
    bus.cam_en   = 1'b0;
    bus.pwdn_req = 1'b1;
    @(posedge clk);
    #1;
    chk_pins("off_wins_pins", P_OFF);
    chk("off_frame_clr", int'(bus.frame_cnt), 0);
    chk("off_line_clr", int'(bus.line_cnt), 0);
    @(negedge clk);
    bus.pwdn_req = 1'b0;

    @(negedge clk);
    bus.cam_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_pins("abort_in_clk_on", 6'b100000);
    @(negedge clk);
    bus.cam_en = 1'b0;
    @(posedge clk);
    #1;
    chk_pins("abort_pins", P_OFF);
    @(negedge clk);
    run_pwrup("restart");

    @(negedge clk);
    bus.cam_en = 1'b0;
    @(negedge clk);
    bus.cam_en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk_pins("pre_rst_rel", 6'b101100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_pins("async_rst_pins", P_OFF);
    repeat (2) @(negedge clk);
    chk_pins("held_rst_pins", P_OFF);
    rst_n = 1'b1;
    run_pwrup("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
